// File: rtl/stream_id_demux.sv
// Packet-level 1-to-S stream demultiplexer with a one-entry register slice per output channel.
// Optional drop counter (drop_cnt_o) enabled by defining STREAM_ID_DEMUX_DROP_CNT_EN.
//
// state | meaning
// IDLE  | next input beat is the first of a packet; target taken from s_id_i
// ROUTE | mid-packet, forwarding to the locked channel sel_q
// DROP  | mid-packet with an out-of-range id, beats consumed and discarded
module stream_id_demux #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [T_DATA_WIDTH-1:0]              s_data_i,
    input  logic [T_ID___WIDTH-1:0]              s_id_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] m_data_o,
    output logic [S_DATA_COUNT-1:0]              m_last_o,
    output logic [S_DATA_COUNT-1:0]              m_valid_o,
`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
    output logic [15:0]                          drop_cnt_o,
`endif
    input  logic [S_DATA_COUNT-1:0]              m_ready_i
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                    state_q, state_nxt;
    logic [T_ID___WIDTH-1:0]   sel_q, sel_nxt;
    logic [S_DATA_COUNT-1:0]   slot_free;
    logic [S_DATA_COUNT-1:0]   load_en;
    logic                      id_ok;
    logic                      ready_c;
    logic                      hs;

    assign slot_free = ~m_valid_o | m_ready_i;
    assign id_ok     = (32'(s_id_i) < S_DATA_COUNT);
    assign s_ready_o = ready_c;

    // ready depends only on state, id and slot status, never on s_valid_i
    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        ready_c   = 1'b0;
        load_en   = '0;
        hs        = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = id_ok ? slot_free[s_id_i] : 1'b1;
                hs      = s_valid_i & ready_c;
                if (hs) begin
                    if (id_ok) begin
                        load_en[s_id_i] = 1'b1;
                    end
                    if (!s_last_i) begin
                        state_nxt = id_ok ? ROUTE : DROP;
                        sel_nxt   = id_ok ? s_id_i : sel_q;
                    end
                end
            end
            ROUTE: begin
                ready_c = slot_free[sel_q];
                hs      = s_valid_i & ready_c;
                if (hs) begin
                    load_en[sel_q] = 1'b1;
                    if (s_last_i) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                ready_c = 1'b1;
                hs      = s_valid_i;
                if (hs && s_last_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst_i) begin
            ready_c = 1'b0;
            load_en = '0;
            hs      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            m_data_o  <= '0;
            m_last_o  <= '0;
            m_valid_o <= '0;
        end else begin
            state_q <= state_nxt;
            sel_q   <= sel_nxt;
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                if (load_en[k]) begin
                    m_data_o[k*T_DATA_WIDTH +: T_DATA_WIDTH] <= s_data_i;
                    m_last_o[k]  <= s_last_i;
                    m_valid_o[k] <= 1'b1;
                end else if (m_ready_i[k]) begin
                    m_valid_o[k] <= 1'b0;
                end
            end
        end
    end

`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
    // one count per discarded packet, taken on its first beat
    logic drop_inc;
    assign drop_inc = (state_q == IDLE) & hs & ~id_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (drop_inc && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_id_demux.sv
// Directed scoreboard bench for stream_id_demux with three output channels.
module tb_stream_id_demux;

    localparam int W = 8;
    localparam int S = 3;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [W-1:0]   s_data_i;
    logic [1:0]     s_id_i;
    logic           s_last_i;
    logic           s_valid_i;
    logic           s_ready_o;
    logic [S*W-1:0] m_data_o;
    logic [S-1:0]   m_last_o;
    logic [S-1:0]   m_valid_o;
    logic [S-1:0]   m_ready_i;
`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] q [S][$];

    stream_id_demux #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S)) dut (
`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
        .drop_cnt_o(drop_cnt),
`endif
        .clk_i(clk_i),
        .rst_i(rst_i),
        .s_data_i(s_data_i),
        .s_id_i(s_id_i),
        .s_last_i(s_last_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o(m_data_o),
        .m_last_o(m_last_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one beat (caller sits just after a rising edge), waits for the handshake,
    // queues the expected output and checks it shows up right after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic [1:0] id, input logic last,
                             input int ch, output int waited);
        int n = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_id_i    = id;
        s_last_i  = last;
        forever begin
            @(negedge clk_i);
            if (s_ready_o) break;
            n++;
            if (n >= 200) begin
                chk("handshake_timeout", n, 0);
                s_valid_i = 1'b0;
                waited = n;
                return;
            end
            @(posedge clk_i); #1;
        end
        if (ch < S) q[ch].push_back({last, d});
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        if (ch < S) begin
            chk("lat_valid", 32'(m_valid_o[ch]), 1);
            chk("lat_data", 32'(m_data_o[ch*W +: W]), 32'(d));
            chk("lat_last", 32'(m_last_o[ch]), 32'(last));
        end else begin
            chk("drop_no_valid", 32'(m_valid_o), 0);
        end
        waited = n;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < S; k++) begin
                if (m_valid_o[k] && m_ready_i[k]) begin
                    if (q[k].size() == 0) begin
                        chk("sb_unexpected_beat", 32'(q[k].size()), 1);
                    end else begin
                        chk("sb_beat", 32'({m_last_o[k], m_data_o[k*W +: W]}), 32'(q[k].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int w;
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_id_i    = '0;
        s_last_i  = 1'b0;
        m_ready_i = '1;

        @(negedge clk_i);
        chk("ready_in_reset", 32'(s_ready_o), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid", 32'(m_valid_o), 0);
        chk("rst_data", 32'(m_data_o), 0);
        chk("rst_last", 32'(m_last_o), 0);
        chk("idle_ready", 32'(s_ready_o), 1);
`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
        @(posedge clk_i); #1;

        // 3-beat packet to channel 2, full throughput
        send_beat(8'h11, 2'd2, 1'b0, 2, w); chk("t1_wait", w, 0);
        chk("t1_onehot", 32'(m_valid_o), 32'b100);
        send_beat(8'h22, 2'd2, 1'b0, 2, w); chk("t1_wait", w, 0);
        chk("t1_onehot", 32'(m_valid_o), 32'b100);
        send_beat(8'h33, 2'd2, 1'b1, 2, w); chk("t1_wait", w, 0);
        chk("t1_onehot", 32'(m_valid_o), 32'b100);

        // id changes mid-packet must be ignored
        send_beat(8'h41, 2'd1, 1'b0, 1, w);
        send_beat(8'h42, 2'd0, 1'b0, 1, w);
        send_beat(8'h43, 2'd0, 1'b1, 1, w);
        chk("t2_onehot", 32'(m_valid_o), 32'b010);

        // backpressure on channel 0
        m_ready_i = 3'b110;
        send_beat(8'hA0, 2'd0, 1'b0, 0, w); chk("t3_first_wait", w, 0);
        s_valid_i = 1'b1; s_data_i = 8'hA1; s_id_i = 2'd0; s_last_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("t3_blocked_ready", 32'(s_ready_o), 0);
            chk("t3_hold_data", 32'(m_data_o[0 +: W]), 32'hA0);
            chk("t3_hold_valid", 32'(m_valid_o[0]), 1);
            @(posedge clk_i); #1;
        end
        m_ready_i = 3'b111;
        send_beat(8'hA1, 2'd0, 1'b1, 0, w); chk("t3_release_wait", w, 0);
        send_beat(8'hB0, 2'd0, 1'b0, 0, w); chk("t3_tput_wait", w, 0);
        send_beat(8'hB1, 2'd0, 1'b1, 0, w); chk("t3_tput_wait", w, 0);

        // out-of-range id: consumed and discarded
        repeat (2) @(posedge clk_i); #1;
`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
        chk("t4_drop_cnt_before", 32'(drop_cnt), 0);
`endif
        send_beat(8'hD0, 2'd3, 1'b0, 3, w); chk("t4_drop_wait", w, 0);
        send_beat(8'hD1, 2'd0, 1'b0, 3, w); chk("t4_drop_wait", w, 0);
        send_beat(8'hD2, 2'd1, 1'b0, 3, w); chk("t4_drop_wait", w, 0);
        send_beat(8'hD3, 2'd2, 1'b1, 3, w); chk("t4_drop_wait", w, 0);
`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
        chk("t4_drop_cnt_after", 32'(drop_cnt), 1);
`endif
        send_beat(8'hE0, 2'd0, 1'b0, 0, w);
        send_beat(8'hE1, 2'd0, 1'b1, 0, w);

        // reset mid-packet with a beat still sitting in slot 1
        send_beat(8'h51, 2'd1, 1'b0, 1, w);
        send_beat(8'h52, 2'd1, 1'b0, 1, w);
        m_ready_i = 3'b101;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t5_ready_in_reset", 32'(s_ready_o), 0);
        @(posedge clk_i); #1;
        chk("t5_valid_cleared", 32'(m_valid_o), 0);
`ifdef STREAM_ID_DEMUX_DROP_CNT_EN
        chk("t5_drop_cnt_cleared", 32'(drop_cnt), 0);
`endif
        rst_i = 1'b0;
        for (int k = 0; k < S; k++) q[k].delete();
        m_ready_i = 3'b111;
        send_beat(8'h60, 2'd0, 1'b1, 0, w); chk("t5_after_reset_wait", w, 0);
        chk("t5_onehot", 32'(m_valid_o), 32'b001);

        // back-to-back single-beat packets
        send_beat(8'h70, 2'd0, 1'b1, 0, w); chk("t6_wait", w, 0);
        send_beat(8'h71, 2'd1, 1'b1, 1, w); chk("t6_wait", w, 0);
        chk("t6_onehot", 32'(m_valid_o), 32'b010);
        send_beat(8'h72, 2'd2, 1'b1, 2, w); chk("t6_wait", w, 0);
        chk("t6_onehot", 32'(m_valid_o), 32'b100);
        send_beat(8'h73, 2'd0, 1'b1, 0, w); chk("t6_wait", w, 0);
        chk("t6_onehot", 32'(m_valid_o), 32'b001);

        repeat (3) @(posedge clk_i);
        #1;
        for (int k = 0; k < S; k++) chk("sb_drained", 32'(q[k].size()), 0);
        chk("final_idle_valid", 32'(m_valid_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_id_demux.md
# stream_id_demux

Packet-level 1-to-S demultiplexer for the return path of the stream crossbar: accepts one tagged stream (data, id, last) and steers each packet to the output channel selected by its id, through a one-entry register slice per output. Routing is locked for the whole packet; packets with an out-of-range id are consumed and discarded. Sits downstream of a crossbar master port, fanning traffic back out to per-source channels.

## Interface
- T_DATA_WIDTH, 8, beat data width
- S_DATA_COUNT, 2, number of output channels (≥2)
- T_ID___WIDTH, localparam $clog2(S_DATA_COUNT), id width
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- s_data_i  in  T_DATA_WIDTH  input beat data
- s_id_i  in  T_ID___WIDTH  destination channel; sampled on first beat of packet only
- s_last_i  in  1  last beat of packet
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input beat accepted when s_valid_i & s_ready_o
- m_data_o  out  T_DATA_WIDTH × [S_DATA_COUNT]  per-channel data
- m_last_o  out  S_DATA_COUNT  per-channel last
- m_valid_o  out  S_DATA_COUNT  per-channel valid
- m_ready_i  in  S_DATA_COUNT  per-channel ready

## Operation
- FSM states: IDLE (next beat is first of packet), ROUTE (forwarding to locked channel sel), DROP (discarding).
- IDLE: target = s_id_i. Valid if s_id_i < S_DATA_COUNT. On handshake: if !s_last_i → ROUTE (sel ← s_id_i) when valid, DROP when invalid; if s_last_i → stay IDLE (single-beat packet).
- ROUTE: target = sel; s_id_i ignored. Handshake with s_last_i → IDLE.
- DROP: target none; s_ready_o = 1; beats discarded. Handshake with s_last_i → IDLE.
- Slot k free when !m_valid_o[k] | m_ready_i[k]. s_ready_o = slot[target] free (ROUTE or valid-id IDLE); 1 in DROP or invalid-id IDLE; 0 while rst_i.
- Accepted routed beat loads m_data_o[k], m_last_o[k], sets m_valid_o[k]. m_valid_o[k] clears on m_ready_i[k] with no load that cycle. Load and drain in the same cycle: new beat replaces old, valid stays 1.
- Only the targeted slot changes on input; other slots drain independently.
- m_data_o/m_last_o hold while m_valid_o[k] & !m_ready_i[k].
- Output order within a packet preserved; no beat duplicated or lost on a valid id.

## Timing
- Reset (rst_i high at edge): state IDLE, sel 0, all m_valid_o 0, m_data_o 0, m_last_o 0, drop counter 0. Reset mid-packet abandons packet; beats already in slots are lost; next beat after reset treated as first.
- Latency: beat accepted at edge n appears on m_*_o[k] after edge n, valid during cycle n+1.
- Throughput: 1 beat/cycle when m_ready_i[target] held high.
- s_ready_o combinational from state, s_id_i, m_valid_o, m_ready_i; no combinational path s_valid_i → s_ready_o.
- m_valid_o, m_data_o, m_last_o are registered outputs.
- s_valid_i low: no state change, slots drain normally.

## Configuration
- STREAM_ID_DEMUX_DROP_CNT_EN defined: adds output port drop_cnt_o (16 bits), counts packets entering DROP or single-beat invalid packets (increment on first-beat handshake with invalid id), saturates at 16'hFFFF, cleared by rst_i.
- Undefined: port and counter absent; drop behaviour otherwise identical.

## Test plan
- S_DATA_COUNT=3: 3-beat packet id=2 data 0x11,0x22,0x33 with all m_ready_i=1 → m_valid_o=3'b100 for 3 consecutive cycles starting 1 cycle after first accept, data 0x11,0x22,0x33, m_last_o[2] only on 0x33.
- Packet id=1 with s_id_i changed to 0 on beats 2-3 → all beats on channel 1 only.
- Hold m_ready_i[0]=0, send 2-beat packet id=0 → first beat held on m_data_o[0], s_ready_o=0 on second beat until m_ready_i[0]=1, then 1 beat/cycle.
- S_DATA_COUNT=3, 4-beat packet id=3 → s_ready_o=1 all beats, m_valid_o stays 0, drop_cnt_o 0→1 (macro defined); following id=0 packet routes normally.
- Assert rst_i mid-packet (after beat 2 of 4, id=1) → next edge m_valid_o=0, state IDLE; next beat with id=0 routed to channel 0.
- Back-to-back single-beat packets id=0,1,2,0 with all ready → one beat per cycle on respective channel, no bubbles.
